// File: rtl/write_back.sv
// Write-back stage: registers the MEM-stage result, selects the register-file
// write data/destination, counts retired instructions and runs the halt sequence.
module write_back (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic [31:0] inst_addr,
    input  logic [4:0]  rt_num,
    input  logic [4:0]  rd_field,
    input  logic [1:0]  destination_register,
    input  logic [1:0]  register_src,
    input  logic        register_write_in,
    input  logic        is_word,
    input  logic        is_nop,
    input  logic        halted_controller_in,
    input  logic [1:0]  byte_offset,
    output logic [4:0]  rd_num,
    output logic [31:0] rd_data,
    output logic        register_write_out,
    output logic        halted,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [31:0] inst_addr;
        logic [4:0]  rt_num;
        logic [4:0]  rd_field;
        logic [1:0]  dest;
        logic [1:0]  src;
        logic        reg_write;
        logic        is_word;
        logic        is_nop;
        logic        halt;
        logic [1:0]  byte_offset;
    } wb_t;

    wb_t         wb_q, wb_d;
    logic        valid_q, valid_d;
    logic        fresh_q, fresh_d;
    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        live;
    logic [7:0]  load_byte;

    // fresh marks the single cycle an instruction is allowed to act; a stall clears it
    always_comb begin
        wb_d    = wb_q;
        valid_d = valid_q;
        fresh_d = 1'b0;
        if (!stall) begin
            wb_d.alu_result  = alu_result;
            wb_d.mem_data    = mem_data;
            wb_d.inst_addr   = inst_addr;
            wb_d.rt_num      = rt_num;
            wb_d.rd_field    = rd_field;
            wb_d.dest        = destination_register;
            wb_d.src         = register_src;
            wb_d.reg_write   = register_write_in;
            wb_d.is_word     = is_word;
            wb_d.is_nop      = is_nop;
            wb_d.halt        = halted_controller_in;
            wb_d.byte_offset = byte_offset;
            valid_d          = in_valid;
            fresh_d          = 1'b1;
        end
    end

    assign live = valid_q & fresh_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (live && wb_q.halt) state_d = DRAIN;
            DRAIN:   state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (live && !wb_q.is_nop && state_q != HALTED && retired_q != '1)
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            wb_q      <= '0;
            valid_q   <= 1'b0;
            fresh_q   <= 1'b0;
            state_q   <= RUN;
            retired_q <= '0;
        end else begin
            wb_q      <= wb_d;
            valid_q   <= valid_d;
            fresh_q   <= fresh_d;
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        rd_num = '0;
        case (wb_q.dest)
            2'b00:   rd_num = wb_q.rt_num;
            2'b01:   rd_num = wb_q.rd_field;
            2'b10:   rd_num = 5'd31;
            default: rd_num = '0;
        endcase
    end

    always_comb begin
        load_byte = '0;
        case (wb_q.byte_offset)
            2'd0:    load_byte = wb_q.mem_data[7:0];
            2'd1:    load_byte = wb_q.mem_data[15:8];
            2'd2:    load_byte = wb_q.mem_data[23:16];
            default: load_byte = wb_q.mem_data[31:24];
        endcase
    end

    always_comb begin
        rd_data = wb_q.alu_result;
        case (wb_q.src)
            2'b01:   rd_data = wb_q.is_word ? wb_q.mem_data : {24'd0, load_byte};
            2'b10:   rd_data = wb_q.inst_addr + 32'd4;
            default: rd_data = wb_q.alu_result;
        endcase
    end

    assign register_write_out = live & wb_q.reg_write & ~wb_q.is_nop
                              & (rd_num != 5'd0) & (state_q != HALTED);
    assign halted        = (state_q == HALTED);
    assign retired_count = retired_q;

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_b  input  1  reset, asynchronous, active-high (asserted = 1) despite the name.
REQ-003 SHALL have port: stall  input  1  hold; when 1, no new instruction is captured.
REQ-004 SHALL have port: in_valid  input  1  MEM stage presents an instruction this cycle.
REQ-005 SHALL have ports: alu_result, mem_data, inst_addr  input  32 each  ALU result, memory read word, instruction address.
REQ-006 SHALL have ports: rt_num, rd_field  input  5 each  inst[20:16] and inst[15:11].
REQ-007 SHALL have port: destination_register  input  2  00 rt, 01 rd, 10 ra (r31), 11 none.
REQ-008 SHALL have port: register_src  input  2  00 ALU, 01 memory, 10 inst_addr+4, 11 ALU.
REQ-009 SHALL have ports: register_write_in, is_word, is_nop, halted_controller_in  input  1 each.
REQ-010 SHALL have port: byte_offset  input  2  byte lane for byte loads.
REQ-011 SHALL have outputs: rd_num 5, rd_data 32, register_write_out 1  regfile write port.
REQ-012 SHALL have outputs: halted 1 (sticky halt), retired_count 32 (retired instruction count).

Function
REQ-013 Capture: on a rising edge with stall=0, the WB register SHALL load all inputs and set valid=in_valid.
REQ-014 With stall=1, the WB register and valid SHALL hold their values.
REQ-015 A fresh flag SHALL be set on capture and cleared on the next edge, so each instruction drives a write for exactly one cycle.
REQ-016 rd_num SHALL be derived from the registered destination_register:
  - 00 gives rt_num
  - 01 gives rd_field
  - 10 gives 31
  - 11 gives 0
REQ-017 rd_data SHALL be derived from the registered register_src:
  - 00 or 11 gives alu_result
  - 10 gives inst_addr+4, mod 2^32 (inst_addr 0xFFFFFFFC yields 0x00000000)
REQ-018 For register_src=01: is_word=1 SHALL give mem_data; is_word=0 SHALL give mem_data[8*byte_offset+7 : 8*byte_offset], zero-extended to 32 bits.
REQ-019 register_write_out SHALL be valid & fresh & register_write_in & ~is_nop & (rd_num!=0) & (state!=HALTED), all from registered values.
REQ-020 rd_num and rd_data SHALL be combinational from the WB register; they are don't-care when register_write_out=0.
REQ-021 The halt FSM SHALL have states RUN, DRAIN, HALTED.
REQ-022 RUN->DRAIN SHALL occur on the edge after a captured instruction has valid & fresh & halted_controller_in.
REQ-023 DRAIN->HALTED SHALL occur on the next edge, independent of stall.
REQ-024 HALTED SHALL persist until reset.
REQ-025 halted SHALL be 1 exactly when state=HALTED.
REQ-026 The halt-tagged instruction itself SHALL retire normally, including its write if enabled.
REQ-027 In DRAIN and HALTED, new captures SHALL still update the WB register, but register_write_out SHALL be 0 in HALTED.
REQ-028 retired_count SHALL increment by 1 on each edge where valid & fresh & ~is_nop and state is not HALTED.
REQ-029 retired_count SHALL saturate at 0xFFFFFFFF.
REQ-030 Simultaneous stall=1 with a fresh instruction SHALL clear fresh, retiring the held instruction once, not repeatedly.
REQ-031 Latency: an instruction presented at edge N SHALL drive register_write_out during cycle N..N+1; halted SHALL rise two edges after capture of the halt instruction.

Reset
REQ-032 While rst_b=1, asynchronously, the block SHALL hold: WB register cleared, valid=0, fresh=0, state=RUN, retired_count=0.
REQ-033 While rst_b=1, outputs SHALL read rd_num=0, rd_data=0, register_write_out=0, halted=0.
REQ-034 Reset asserted mid-DRAIN or in HALTED SHALL return the FSM to RUN immediately, with no write issued.
REQ-035 After rst_b deasserts, the first capture SHALL occur on the first rising edge with stall=0.

Verification
REQ-036 ALU write: in_valid=1, dest=01, rd_field=5, src=00, alu_result=0x1234, register_write_in=1 -> one cycle register_write_out=1, rd_num=5, rd_data=0x1234; retired_count=1.
REQ-037 Byte load: src=01, is_word=0, mem_data=0xAABBCCDD, byte_offset=2, dest=00, rt_num=9 -> rd_num=9, rd_data=0x000000BB.
REQ-038 JAL link: dest=10, src=10, inst_addr=0x00400010 -> rd_num=31, rd_data=0x00400014.
REQ-039 Write to r0 and is_nop: dest=00, rt_num=0 -> register_write_out=0; an is_nop instruction -> retired_count unchanged.
REQ-040 Stall: capture a write, hold stall=1 for 3 cycles -> register_write_out high 1 cycle only, retired_count +1.
REQ-041 Halt: a halted_controller_in instruction writing r2 -> write occurs, halted=1 two edges later.
REQ-042 Post-halt and reset: after halt, further writes are suppressed; rst_b pulse -> halted=0, retired_count=0.
